// File: rtl/rv32i_boot_pkg.sv
// Shared types and constants for the rv32i boot loader.
//   boot_state_e : loader FSM states
//   HDR_BYTES    : bytes per header field (load address, length)
//   wstrb_t      : per-byte write enable of one 32-bit memory word
package rv32i_boot_pkg;

    typedef enum logic [2:0] {
        HDR_ADDR = 3'd0,
        HDR_LEN  = 3'd1,
        PAYLOAD  = 3'd2,
        CHECKSUM = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } boot_state_e;

    localparam int HDR_BYTES = 4;

    typedef logic [3:0] wstrb_t;

endpackage

// File: rtl/rv32i_word_packer.sv
// Packs payload bytes into little-endian memory words.
// Each byte is steered to its lane and its strobe bit is accumulated. A word
// is written when lane 3 fills or when flush marks the final byte. clear drops
// any partial word. All memory-side outputs are registered, so mem_we pulses
// for exactly one cycle after the completing byte.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   byte_valid, byte_data   : byte to pack this cycle
//   byte_lane, word_addr    : lane and word address of that byte
//   flush                   : this byte is the final payload byte
//   clear                   : discard the accumulated partial word
//   mem_we/addr/wdata/wstrb : registered write to instruction memory
module rv32i_word_packer
    import rv32i_boot_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic [1:0]            byte_lane,
    input  logic [ADDR_WIDTH-3:0] word_addr,
    input  logic                  flush,
    input  logic                  clear,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output wstrb_t                mem_wstrb
);

    logic [XLEN-1:0]       acc_data_r;
    wstrb_t                acc_strb_r;
    logic [XLEN-1:0]       merged_data_s;
    wstrb_t                merged_strb_s;
    logic                  emit_s;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [XLEN-1:0]       wdata_r;
    wstrb_t                wstrb_r;

    // Merge the incoming byte into the partial word and decide whether it completes.
    always_comb begin
        merged_data_s = acc_data_r;
        merged_data_s[{byte_lane, 3'b000} +: 8] = byte_data;
        merged_strb_s = acc_strb_r | (4'b0001 << byte_lane);
        emit_s        = flush | (byte_lane == 2'd3);
    end

    // Accumulator and registered memory write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_data_r <= '0;
            acc_strb_r <= 4'b0000;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            wstrb_r    <= 4'b0000;
        end else begin
            we_r <= 1'b0;
            if (byte_valid && emit_s) begin
                // Packer empties in the same cycle so the next byte is never stalled.
                we_r       <= 1'b1;
                addr_r     <= {word_addr, 2'b00};
                wdata_r    <= merged_data_s;
                wstrb_r    <= merged_strb_s;
                acc_data_r <= '0;
                acc_strb_r <= 4'b0000;
            end else if (clear) begin
                acc_data_r <= '0;
                acc_strb_r <= 4'b0000;
            end else if (byte_valid) begin
                acc_data_r <= merged_data_s;
                acc_strb_r <= merged_strb_s;
            end else begin
                acc_data_r <= acc_data_r;
                acc_strb_r <= acc_strb_r;
            end
        end
    end

    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_wstrb = wstrb_r;

endmodule

// File: rtl/rv32i_boot_loader.sv
// Synthesizable boot loader: receives a framed byte stream
// (4-byte LE load address, 4-byte LE length N, N payload bytes), writes the
// payload into instruction memory and then releases the core from reset.
// Any framing or range fault parks the loader in ERROR with the core held.
// Optional build macro RV32I_BOOT_CHECKSUM_EN: one checksum byte follows the
// payload; payload bytes plus checksum must sum to 0 mod 256.
// Ports:
//   clock, reset                     : clock, synchronous active-high reset
//   s_valid, s_ready, s_data, s_last : byte stream input
//   mem_we/addr/wdata/wstrb          : instruction memory write port
//   core_reset_n                     : active-low reset to the core
//   load_done, load_error            : final status
module rv32i_boot_loader
    import rv32i_boot_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [3:0]            mem_wstrb,
    output logic                  core_reset_n,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [2:0]  HDR_ADDR_END = 3'(HDR_BYTES - 1);
    localparam logic [2:0]  HDR_LEN_END  = 3'(2 * HDR_BYTES - 1);
    localparam logic [32:0] MEM_BYTES    = 33'd1 << ADDR_WIDTH;

    boot_state_e           state_r;
    boot_state_e           state_nxt_s;
    logic                  ready_r;
    logic [2:0]            hdr_cnt_r;
    logic [31:0]           pay_cnt_r;
    logic [31:0]           addr_r;
    logic [31:0]           len_r;
    logic [ADDR_WIDTH-1:0] cur_addr_r;
    logic                  load_done_r;
    logic                  load_error_r;
    logic                  core_rst_n_r;
    logic                  acc_s;
    logic [31:0]           len_full_s;
    logic [32:0]           range_sum_s;
    logic                  range_bad_s;
    logic                  last_pay_s;
    logic                  pk_valid_s;
    logic                  pk_flush_s;
    logic                  pk_clear_s;
`ifdef RV32I_BOOT_CHECKSUM_EN
    logic [7:0]            csum_r;
    logic [7:0]            csum_nxt_s;
`endif

    // Reset wins over a coincident byte: ready is masked while reset is high.
    assign s_ready = ready_r & ~reset;
    assign acc_s   = s_valid & s_ready;

    // Next-state logic and packer control.
    always_comb begin
        state_nxt_s = state_r;
        pk_valid_s  = 1'b0;
        pk_flush_s  = 1'b0;
        pk_clear_s  = 1'b0;
        len_full_s  = {s_data, len_r[31:8]};
        // 33-bit sum so an address/length wrap can never pass the range check.
        range_sum_s = {1'b0, addr_r} + {1'b0, len_full_s};
        range_bad_s = (range_sum_s > MEM_BYTES);
        last_pay_s  = (pay_cnt_r == (len_r - 32'd1));
`ifdef RV32I_BOOT_CHECKSUM_EN
        csum_nxt_s  = csum_r + s_data;
`endif
        case (state_r)
            HDR_ADDR: begin
                if (!acc_s) begin
                    state_nxt_s = HDR_ADDR;
                end else if (s_last) begin
                    state_nxt_s = ERROR;
                end else if (hdr_cnt_r == HDR_ADDR_END) begin
                    state_nxt_s = HDR_LEN;
                end else begin
                    state_nxt_s = HDR_ADDR;
                end
            end
            HDR_LEN: begin
                if (!acc_s) begin
                    state_nxt_s = HDR_LEN;
                end else if (hdr_cnt_r != HDR_LEN_END) begin
                    state_nxt_s = s_last ? ERROR : HDR_LEN;
                end else if (range_bad_s) begin
                    state_nxt_s = ERROR;
                end else if (len_full_s == 32'd0) begin
`ifdef RV32I_BOOT_CHECKSUM_EN
                    state_nxt_s = s_last ? ERROR : CHECKSUM;
`else
                    state_nxt_s = s_last ? DONE : ERROR;
`endif
                end else begin
                    state_nxt_s = s_last ? ERROR : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!acc_s) begin
                    state_nxt_s = PAYLOAD;
                end else if (last_pay_s) begin
                    pk_valid_s = 1'b1;
`ifdef RV32I_BOOT_CHECKSUM_EN
                    // s_last belongs on the checksum byte, not on the last payload byte.
                    if (s_last) begin
                        pk_clear_s  = 1'b1;
                        state_nxt_s = ERROR;
                    end else begin
                        pk_flush_s  = 1'b1;
                        state_nxt_s = CHECKSUM;
                    end
`else
                    if (s_last) begin
                        pk_flush_s  = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        pk_clear_s  = 1'b1;
                        state_nxt_s = ERROR;
                    end
`endif
                end else if (s_last) begin
                    // Premature end of frame: a word completed by this byte still
                    // lands, anything partial is dropped.
                    pk_valid_s  = 1'b1;
                    pk_clear_s  = 1'b1;
                    state_nxt_s = ERROR;
                end else begin
                    pk_valid_s  = 1'b1;
                    state_nxt_s = PAYLOAD;
                end
            end
            CHECKSUM: begin
`ifdef RV32I_BOOT_CHECKSUM_EN
                if (!acc_s) begin
                    state_nxt_s = CHECKSUM;
                end else if (s_last && (csum_nxt_s == 8'd0)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ERROR;
                end
`else
                state_nxt_s = ERROR;
`endif
            end
            DONE:    state_nxt_s = DONE;
            ERROR:   state_nxt_s = ERROR;
            default: state_nxt_s = ERROR;
        endcase
    end

    // State, header capture, counters and status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= HDR_ADDR;
            ready_r      <= 1'b1;
            hdr_cnt_r    <= 3'd0;
            pay_cnt_r    <= 32'd0;
            addr_r       <= 32'd0;
            len_r        <= 32'd0;
            cur_addr_r   <= '0;
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
            core_rst_n_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ready_r      <= (state_nxt_s == HDR_ADDR) || (state_nxt_s == HDR_LEN) ||
                            (state_nxt_s == PAYLOAD)  || (state_nxt_s == CHECKSUM);
            load_error_r <= (state_nxt_s == ERROR);
            // One cycle behind DONE so the final word is in memory before release.
            load_done_r  <= (state_r == DONE);
            core_rst_n_r <= (state_r == DONE);
            if (acc_s) begin
                case (state_r)
                    HDR_ADDR: begin
                        addr_r    <= {s_data, addr_r[31:8]};
                        hdr_cnt_r <= hdr_cnt_r + 3'd1;
                    end
                    HDR_LEN: begin
                        len_r      <= len_full_s;
                        hdr_cnt_r  <= hdr_cnt_r + 3'd1;
                        cur_addr_r <= addr_r[ADDR_WIDTH-1:0];
                    end
                    PAYLOAD: begin
                        pay_cnt_r  <= pay_cnt_r + 32'd1;
                        cur_addr_r <= cur_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                    default: begin
                        pay_cnt_r <= pay_cnt_r;
                    end
                endcase
            end
        end
    end

`ifdef RV32I_BOOT_CHECKSUM_EN
    // Running modulo-256 sum of payload bytes.
    always_ff @(posedge clock) begin
        if (reset) begin
            csum_r <= 8'd0;
        end else if (acc_s && (state_r == PAYLOAD)) begin
            csum_r <= csum_nxt_s;
        end else begin
            csum_r <= csum_r;
        end
    end
`endif

    rv32i_word_packer #(
        .XLEN       (XLEN),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (pk_valid_s),
        .byte_data  (s_data),
        .byte_lane  (cur_addr_r[1:0]),
        .word_addr  (cur_addr_r[ADDR_WIDTH-1:2]),
        .flush      (pk_flush_s),
        .clear      (pk_clear_s),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb)
    );

    assign core_reset_n = core_rst_n_r;
    assign load_done    = load_done_r;
    assign load_error   = load_error_r;

endmodule

// File: tb/tb_rv32i_boot_loader.sv
// Directed testbench for rv32i_boot_loader. Expected memory writes are queued
// when a frame is driven and popped when mem_we is seen.
`timescale 1ns/1ps
module tb_rv32i_boot_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        core_reset_n;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;
    wr_t exp_q[$];
    logic [7:0] csum;

    logic [7:0] t1_bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    rv32i_boot_loader #(.XLEN(32), .ADDR_WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .core_reset_n (core_reset_n),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_t e;
        e.a = a;
        e.d = d;
        e.s = s;
        exp_q.push_back(e);
    endtask

    // Advance to the next falling edge and score any write made in that cycle.
    task automatic tick();
        wr_t e;
        @(negedge clock);
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(mem_we), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e.a));
                chk("wr_data", 64'(mem_wdata), 64'(e.d));
                chk("wr_strb", 64'(mem_wstrb), 64'(e.s));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] a, input logic [31:0] n, input logic last8);
        csum = 8'h00;
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b0);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], last8 && (i == 3));
    endtask

    // Send a payload byte; fin marks the final one (followed by a valid
    // checksum byte when the checksum build is selected).
    task automatic send_pay(input logic [7:0] d, input logic fin);
`ifdef RV32I_BOOT_CHECKSUM_EN
        logic [7:0] c;
        csum = csum + d;
        send_byte(d, 1'b0);
        if (fin) begin
            c = 8'h00 - csum;
            send_byte(c, 1'b1);
        end
`else
        send_byte(d, fin);
`endif
    endtask

    task automatic do_reset();
        chk("missing_write", 64'(exp_q.size()), 64'd0);
        s_valid = 1'b0;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
    endtask

    initial begin
        // Reset values
        #1;
        chk("rst_ready", 64'(s_ready), 64'd0);
        tick();
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst_core_n", 64'(core_reset_n), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_error", 64'(load_error), 64'd0);
        chk("rst_ready_held", 64'(s_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 64'(s_ready), 64'd1);

        // Aligned load of two words
        exp_wr(16'h0000, 32'h0000_0013, 4'hF);
        exp_wr(16'h0004, 32'h0010_0093, 4'hF);
        send_hdr(32'h0000_0000, 32'd8, 1'b0);
        for (int i = 0; i < 8; i++) send_pay(t1_bytes[i], i == 7);
        chk("t1_done_early", 64'(load_done), 64'd0);
        chk("t1_core_early", 64'(core_reset_n), 64'd0);
        chk("t1_ready_done", 64'(s_ready), 64'd0);
        tick();
        chk("t1_done", 64'(load_done), 64'd1);
        chk("t1_core_run", 64'(core_reset_n), 64'd1);
        chk("t1_error", 64'(load_error), 64'd0);

        // Unaligned start and end give partial strobes
        do_reset();
        exp_wr(16'h0100, 32'hBBAA_0000, 4'b1100);
        exp_wr(16'h0104, 32'h0000_00CC, 4'b0001);
        send_hdr(32'h0000_0102, 32'd3, 1'b0);
        send_pay(8'hAA, 1'b0);
        send_pay(8'hBB, 1'b0);
        send_pay(8'hCC, 1'b1);
        tick();
        chk("t2_done", 64'(load_done), 64'd1);

        // Range fault: 0xFFFE + 4 exceeds 64 KiB
        do_reset();
        send_hdr(32'h0000_FFFE, 32'd4, 1'b0);
        chk("t3_error", 64'(load_error), 64'd1);
        chk("t3_ready", 64'(s_ready), 64'd0);
        chk("t3_core_n", 64'(core_reset_n), 64'd0);
        tick();
        tick();
        chk("t3_error_hold", 64'(load_error), 64'd1);
        chk("t3_done", 64'(load_done), 64'd0);

        // Exact fit at the top of memory is allowed
        do_reset();
        exp_wr(16'hFFFC, 32'h4433_2211, 4'hF);
        send_hdr(32'h0000_FFFC, 32'd4, 1'b0);
        send_pay(8'h11, 1'b0);
        send_pay(8'h22, 1'b0);
        send_pay(8'h33, 1'b0);
        send_pay(8'h44, 1'b1);
        tick();
        chk("t3b_done", 64'(load_done), 64'd1);
        chk("t3b_error", 64'(load_error), 64'd0);

        // Early s_last on byte 4 of 6: completed word lands, then error
        do_reset();
        exp_wr(16'h0400, 32'hA3A2_A1A0, 4'hF);
        send_hdr(32'h0000_0400, 32'd6, 1'b0);
        send_byte(8'hA0, 1'b0);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b1);
        chk("t4_error", 64'(load_error), 64'd1);
        tick();
        tick();
        chk("t4_core_n", 64'(core_reset_n), 64'd0);
        chk("t4_done", 64'(load_done), 64'd0);

        // Early s_last inside a partial word: nothing written
        do_reset();
        send_hdr(32'h0000_0600, 32'd6, 1'b0);
        send_byte(8'hB0, 1'b0);
        send_byte(8'hB1, 1'b1);
        chk("t4b_error", 64'(load_error), 64'd1);
        tick();
        tick();

        // Reset coinciding with payload byte 5, then a fresh frame
        do_reset();
        exp_wr(16'h0200, 32'h4443_4241, 4'hF);
        send_hdr(32'h0000_0200, 32'd8, 1'b0);
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b0);
        send_byte(8'h44, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h45;
        reset   = 1'b1;
        #1;
        chk("t5_ready_in_rst", 64'(s_ready), 64'd0);
        tick();
        s_valid = 1'b0;
        reset   = 1'b0;
        chk("t5_core_n", 64'(core_reset_n), 64'd0);
        chk("t5_we", 64'(mem_we), 64'd0);
        exp_wr(16'h0300, 32'h7856_3412, 4'hF);
        send_hdr(32'h0000_0300, 32'd4, 1'b0);
        send_pay(8'h12, 1'b0);
        send_pay(8'h34, 1'b0);
        send_pay(8'h56, 1'b0);
        send_pay(8'h78, 1'b1);
        tick();
        chk("t5_done", 64'(load_done), 64'd1);

        // Zero-length image
        do_reset();
`ifdef RV32I_BOOT_CHECKSUM_EN
        send_hdr(32'h0000_0800, 32'd0, 1'b0);
        send_byte(8'h00, 1'b1);
`else
        send_hdr(32'h0000_0800, 32'd0, 1'b1);
`endif
        chk("t6_error", 64'(load_error), 64'd0);
        tick();
        chk("t6_done", 64'(load_done), 64'd1);

`ifdef RV32I_BOOT_CHECKSUM_EN
        // Good checksum
        do_reset();
        exp_wr(16'h0500, 32'h0403_0201, 4'hF);
        send_hdr(32'h0000_0500, 32'd4, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'hF6, 1'b1);
        chk("t7_error", 64'(load_error), 64'd0);
        tick();
        chk("t7_done", 64'(load_done), 64'd1);

        // Bad checksum: word still written, then error
        do_reset();
        exp_wr(16'h0500, 32'h0403_0201, 4'hF);
        send_hdr(32'h0000_0500, 32'd4, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'hF5, 1'b1);
        chk("t7b_error", 64'(load_error), 64'd1);
        tick();
        chk("t7b_done", 64'(load_done), 64'd0);
        chk("t7b_core_n", 64'(core_reset_n), 64'd0);
`else
        // Final byte without s_last: error, partial word dropped
        do_reset();
        send_hdr(32'h0000_0700, 32'd2, 1'b0);
        send_byte(8'hC0, 1'b0);
        send_byte(8'hC1, 1'b0);
        chk("t8_error", 64'(load_error), 64'd1);
        tick();
        tick();
        chk("t8_done", 64'(load_done), 64'd0);
`endif

        chk("missing_write_end", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
